// File: rtl/gamma_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// gamma_cycle_sequencer : reset / run-window / timestamp sequencer for a
//                         race-logic primitive array.       Revision: 1.0
// ============================================================================
module gamma_cycle_sequencer #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int RST_CYCLES        = 1,
    parameter int NUM_LANES         = 4,
    localparam int TW               = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
    input  logic                    aclk,
    input  logic                    grst,
    input  logic                    start,
    input  logic                    cont,
    input  logic                    stop,
    input  logic [NUM_LANES-1:0]    lane_q,
    output logic                    gamma_rst,
    output logic                    in_en,
    output logic [TW-1:0]           gamma_tick,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_LANES-1:0]    spike_valid,
    output logic [NUM_LANES*TW-1:0] spike_time
);

    localparam int CMAX = (GAMMA_CYCLE_WIDTH > RST_CYCLES) ? GAMMA_CYCLE_WIDTH : RST_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] C_RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] C_RUN_LAST = CW'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [TW-1:0] C_INF      = TW'(GAMMA_CYCLE_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RST    = 2'd1,
        S_RUN    = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    gamma_rst_q, gamma_rst_d;
    logic                    in_en_q, in_en_d;
    logic [TW-1:0]           tick_q, tick_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [NUM_LANES-1:0]    valid_q, valid_d;
    logic [NUM_LANES*TW-1:0] time_q, time_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_RST;
                    cnt_d   = '0;
                end
            end
            S_RST: begin
                if (stop) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == C_RST_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == C_RUN_LAST) begin
                    state_d = S_REPORT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REPORT: begin
                cnt_d   = '0;
                state_d = (cont && !stop) ? S_RST : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered, so they are decoded from the next state.
    always_comb begin
        gamma_rst_d = (state_d == S_RST);
        in_en_d     = (state_d == S_RUN);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_REPORT);
        tick_d      = (state_d == S_RUN) ? cnt_d[TW-1:0] : '0;
    end

    // Results clear on RST entry and otherwise only change on a lane's first RUN high.
    always_comb begin
        valid_d = valid_q;
        time_d  = time_q;
        if (state_d == S_RST && state_q != S_RST) begin
            valid_d = '0;
            time_d  = {NUM_LANES{C_INF}};
        end else if (state_q == S_RUN) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (!valid_q[i] && lane_q[i]) begin
                    valid_d[i]          = 1'b1;
                    time_d[i*TW +: TW]  = cnt_q[TW-1:0];
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (grst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            gamma_rst_q <= 1'b0;
            in_en_q     <= 1'b0;
            tick_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= '0;
            time_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gamma_rst_q <= gamma_rst_d;
            in_en_q     <= in_en_d;
            tick_q      <= tick_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            time_q      <= time_d;
        end
    end

    assign gamma_rst   = gamma_rst_q;
    assign in_en       = in_en_q;
    assign gamma_tick  = tick_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign spike_valid = valid_q;
    assign spike_time  = time_q;

endmodule
`default_nettype wire
